// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES cipher tops and their round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_FIRST,
        ST_ROUND,
        ST_LAST,
        ST_DONE
    } state_e;

    localparam int NR_128      = 10;
    localparam int NR_192      = 12;
    localparam int NR_256      = 14;
    localparam int ROUND_IDX_W = 4;
    localparam int RCNT_W      = 4;
    localparam int KCNT_W      = 5;

endpackage

// File: rtl/aes_round_sequencer.sv
// Round sequencer for an iterative AES datapath: one round per clock, encrypt or decrypt,
// with key-expansion wait and reuse of an already expanded key across jobs.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR       = NR_256,
    parameter int KEY_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   decrypt,
    input  logic                   key_new,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   key_rst,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   sel_first,
    output logic                   sel_last,
    output logic                   load_state,
    output logic                   capture_out
);

    localparam logic [RCNT_W-1:0]      NR_L    = RCNT_W'(NR);
    localparam logic [RCNT_W-1:0]      NR_M1   = RCNT_W'(NR - 1);
    localparam logic [ROUND_IDX_W-1:0] IDX_NR  = ROUND_IDX_W'(NR);
    localparam logic [KCNT_W-1:0]      KW_M1   = KCNT_W'(KEY_WAIT - 1);

    state_e              state_q, state_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [KCNT_W-1:0]   kcnt_q, kcnt_d;
    logic                dir_q, dir_d;
    logic                key_ok_q, key_ok_d;

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        kcnt_d   = kcnt_q;
        dir_d    = dir_q;
        key_ok_d = key_ok_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d = decrypt;
                    if (!key_ok_q || key_new) begin
                        state_d = ST_KEXP;
                        kcnt_d  = '0;
                    end else begin
                        state_d = ST_FIRST;
                    end
                end
            end
            ST_KEXP: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    kcnt_d   = '0;
                    key_ok_d = 1'b0;
                end else if (kcnt_q == KW_M1) begin
                    state_d  = ST_FIRST;
                    kcnt_d   = '0;
                    key_ok_d = 1'b1;
                end else begin
                    kcnt_d = kcnt_q + KCNT_W'(1);
                end
            end
            ST_FIRST: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else begin
                    state_d = ST_ROUND;
                    rcnt_d  = RCNT_W'(1);
                end
            end
            ST_ROUND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == NR_M1) begin
                    state_d = ST_LAST;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
            ST_LAST: begin
                state_d = abort ? ST_IDLE : ST_DONE;
                rcnt_d  = '0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
                kcnt_d  = '0;
            end
        endcase

        // A key change always invalidates the expanded schedule, even alongside abort.
        if (key_new) begin
            key_ok_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rcnt_q   <= '0;
            kcnt_q   <= '0;
            dir_q    <= 1'b0;
            key_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            kcnt_q   <= kcnt_d;
            dir_q    <= dir_d;
            key_ok_q <= key_ok_d;
        end
    end

    // Outputs depend only on registered state, so reset clears them without waiting for an edge.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        key_rst     = (state_q == ST_KEXP) && (kcnt_q == '0);
        sel_first   = (state_q == ST_FIRST);
        sel_last    = (state_q == ST_LAST);
        load_state  = (state_q == ST_FIRST) || (state_q == ST_ROUND) || (state_q == ST_LAST);
        capture_out = (state_q == ST_LAST);
        round_idx   = '0;
        case (state_q)
            ST_FIRST: round_idx = dir_q ? IDX_NR : '0;
            ST_ROUND: round_idx = dir_q ? (NR_L - rcnt_q) : rcnt_q;
            ST_LAST:  round_idx = dir_q ? '0 : IDX_NR;
            default:  round_idx = '0;
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: NR=10 and NR=14 instances, KEY_WAIT=15.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start, decrypt, key_new, abort, sel14;

    logic       a_busy, a_done, a_key_rst, a_sel_first, a_sel_last, a_load, a_capture;
    logic [3:0] a_idx;
    logic       b_busy, b_done, b_key_rst, b_sel_first, b_sel_last, b_load, b_capture;
    logic [3:0] b_idx;

    logic       m_busy, m_done, m_key_rst, m_sel_first, m_sel_last, m_load, m_capture;
    logic [3:0] m_idx;

    int nr_cur;
    int n_checks;
    int n_pass;
    int exp_idx_q[$];
    int exp_done_q[$];

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .KEY_WAIT(15)) dut10 (
        .clk(clk), .rst(rst),
        .start(start & ~sel14), .decrypt(decrypt),
        .key_new(key_new & ~sel14), .abort(abort & ~sel14),
        .busy(a_busy), .done(a_done), .key_rst(a_key_rst), .round_idx(a_idx),
        .sel_first(a_sel_first), .sel_last(a_sel_last),
        .load_state(a_load), .capture_out(a_capture)
    );

    aes_round_sequencer #(.NR(14), .KEY_WAIT(15)) dut14 (
        .clk(clk), .rst(rst),
        .start(start & sel14), .decrypt(decrypt),
        .key_new(key_new & sel14), .abort(abort & sel14),
        .busy(b_busy), .done(b_done), .key_rst(b_key_rst), .round_idx(b_idx),
        .sel_first(b_sel_first), .sel_last(b_sel_last),
        .load_state(b_load), .capture_out(b_capture)
    );

    assign m_busy      = sel14 ? b_busy      : a_busy;
    assign m_done      = sel14 ? b_done      : a_done;
    assign m_key_rst   = sel14 ? b_key_rst   : a_key_rst;
    assign m_sel_first = sel14 ? b_sel_first : a_sel_first;
    assign m_sel_last  = sel14 ? b_sel_last  : a_sel_last;
    assign m_load      = sel14 ? b_load      : a_load;
    assign m_capture   = sel14 ? b_capture   : a_capture;
    assign m_idx       = sel14 ? b_idx       : a_idx;

    task automatic test_reset();
        logic [10:0] obs;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_new = 1'b0; abort = 1'b0;
        sel14 = 1'b0; nr_cur = 10;
        repeat (2) @(negedge clk);
        obs = {a_busy, a_done, a_key_rst, a_sel_first, a_sel_last, a_load, a_capture, a_idx};
        n_checks++;
        if (obs !== 11'd0) $display("FAIL reset_outputs: got %b expected %b", obs, 11'd0);
        else n_pass++;
        n_checks++;
        if (b_busy !== 1'b0) $display("FAIL reset_busy14: got %b expected 0", b_busy);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b expected 0", a_busy);
        else n_pass++;
        $display("reset released, dut idle");
    endtask

    // One job from start to done; key_new is pulsed during cycle kn_at when nonzero.
    task automatic run_job(input bit dec, input int exp_krst, input int exp_done,
                           input int kn_at, input string tag);
        int krst_n = 0;
        int cap_n = 0;
        int ld_n = 0;
        int done_cyc = -1;
        int e;
        for (int r = 0; r <= nr_cur; r++) exp_idx_q.push_back(dec ? nr_cur - r : r);
        start = 1'b1;
        decrypt = dec;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (m_key_rst) krst_n++;
            if (m_capture) cap_n++;
            if (m_load) begin
                ld_n++;
                n_checks++;
                if (exp_idx_q.size() == 0) begin
                    $display("FAIL %s_extra_load: got load at cycle %0d expected none", tag, cyc);
                end else begin
                    e = exp_idx_q.pop_front();
                    if ({28'd0, m_idx} !== 32'(e))
                        $display("FAIL %s_round_idx: got %0d expected %0d (cycle %0d)", tag, m_idx, e, cyc);
                    else n_pass++;
                end
                n_checks++;
                if (m_sel_first !== (ld_n == 1) || m_sel_last !== (ld_n == nr_cur + 1))
                    $display("FAIL %s_selects: got first=%b last=%b expected first=%b last=%b",
                             tag, m_sel_first, m_sel_last, ld_n == 1, ld_n == nr_cur + 1);
                else n_pass++;
            end
            key_new = 1'b0;
            if (cyc == kn_at) key_new = 1'b1;
            if (m_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        key_new = 1'b0;
        n_checks++;
        if (done_cyc != exp_done) $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_cyc, exp_done);
        else n_pass++;
        n_checks++;
        if (krst_n != exp_krst) $display("FAIL %s_key_rst: got %0d expected %0d", tag, krst_n, exp_krst);
        else n_pass++;
        n_checks++;
        if (cap_n != 1) $display("FAIL %s_capture: got %0d expected 1", tag, cap_n);
        else n_pass++;
        n_checks++;
        if (ld_n != nr_cur + 1) $display("FAIL %s_load_count: got %0d expected %0d", tag, ld_n, nr_cur + 1);
        else n_pass++;
        n_checks++;
        if (exp_idx_q.size() != 0) $display("FAIL %s_idx_left: got %0d expected 0", tag, exp_idx_q.size());
        else n_pass++;
        exp_idx_q.delete();
        @(negedge clk);
        n_checks++;
        if ({m_done, m_busy} !== 2'b00) $display("FAIL %s_after_done: got done,busy=%b expected 00", tag, {m_done, m_busy});
        else n_pass++;
        $display("job %s dec=%0d done_cycle=%0d key_rst=%0d loads=%0d", tag, dec, done_cyc, krst_n, ld_n);
    endtask

    task automatic test_key_expand();
        run_job(1'b0, 1, 27, 0, "first");
    endtask

    task automatic test_key_reuse();
        run_job(1'b0, 0, 12, 0, "reuse_enc");
        run_job(1'b1, 0, 12, 0, "reuse_dec");
    endtask

    task automatic test_nr14();
        sel14 = 1'b1;
        nr_cur = 14;
        run_job(1'b0, 1, 31, 0, "nr14_first");
        run_job(1'b1, 0, 16, 0, "nr14_dec");
        sel14 = 1'b0;
        nr_cur = 10;
    endtask

    task automatic test_key_new_busy();
        run_job(1'b0, 0, 12, 4, "kn_job_a");
        run_job(1'b0, 1, 27, 0, "kn_job_b");
    endtask

    task automatic test_abort();
        int bad = 0;
        int e;
        for (int r = 0; r < 4; r++) exp_idx_q.push_back(r);
        start = 1'b1;
        decrypt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            if (m_load && exp_idx_q.size() != 0) begin
                e = exp_idx_q.pop_front();
                n_checks++;
                if ({28'd0, m_idx} !== 32'(e)) $display("FAIL abort_round_idx: got %0d expected %0d", m_idx, e);
                else n_pass++;
            end
            if (cyc == 4) abort = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({m_busy, m_load, m_idx} !== 6'd0) $display("FAIL abort_idle: got busy,load,idx=%b expected 000000", {m_busy, m_load, m_idx});
        else n_pass++;
        n_checks++;
        if (exp_idx_q.size() != 0) $display("FAIL abort_loads: got %0d missing expected 0", exp_idx_q.size());
        else n_pass++;
        exp_idx_q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (m_done || m_capture) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_no_done: got %0d done/capture cycles expected 0", bad);
        else n_pass++;
        $display("job abort at third ROUND cycle, idle next cycle");
        run_job(1'b0, 0, 12, 0, "after_abort");
    endtask

    task automatic test_async_rst();
        logic [10:0] obs;
        start = 1'b1;
        decrypt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({m_capture, m_sel_last} !== 2'b11) $display("FAIL rst_in_last: got capture,sel_last=%b expected 11", {m_capture, m_sel_last});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        obs = {a_busy, a_done, a_key_rst, a_sel_first, a_sel_last, a_load, a_capture, a_idx};
        n_checks++;
        if (obs !== 11'd0) $display("FAIL async_rst_outputs: got %b expected %b", obs, 11'd0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        $display("job async reset during LAST, outputs cleared");
        run_job(1'b0, 1, 27, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        int ld_n = 0;
        int dn = 0;
        int e;
        for (int j = 0; j < 3; j++) exp_done_q.push_back(12 + 13 * j);
        start = 1'b1;
        decrypt = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (m_load) ld_n++;
            if (m_done) begin
                dn++;
                n_checks++;
                if (exp_done_q.size() == 0) begin
                    $display("FAIL b2b_extra_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = exp_done_q.pop_front();
                    if (cyc != e) $display("FAIL b2b_done_cycle: got %0d expected %0d", cyc, e);
                    else n_pass++;
                end
                $display("job b2b_%0d done_cycle=%0d", dn, cyc);
                if (dn == 3) start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (exp_done_q.size() != 0) $display("FAIL b2b_missing_done: got %0d missing expected 0", exp_done_q.size());
        else n_pass++;
        n_checks++;
        if (ld_n != 33) $display("FAIL b2b_load_count: got %0d expected 33", ld_n);
        else n_pass++;
        exp_done_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_key_expand();
        test_key_reuse();
        test_nr14();
        test_key_new_busy();
        test_abort();
        test_async_rst();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
